// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding I-cache request feeding a
// small in-order buffer toward decode, with redirect flush and drop.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h6000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } if_id_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] pc_aligned;

  if_id_t      fifo [BUF_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic full;
  logic issue;
  logic push;
  logic pop;
  logic unused_bits;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign pc_aligned  = {pc[31:2], 2'b00};
  assign unused_bits = ^{redirect_pc[1:0], pc[1:0]};

  assign full  = (count == CW'(BUF_DEPTH));
  assign issue = (state == IDLE) && !redirect && !full;
  assign push  = (state == WAIT) && imem_resp && !redirect;
  assign pop   = if_valid && id_ready && !redirect;

  // Gated by rst so the request drops the instant reset asserts.
  assign imem_read    = rst && (issue || (state != IDLE));
  assign imem_address = (state == IDLE) ? pc_aligned : req_addr;

  assign if_valid       = (count != '0);
  assign if_pc          = fifo[head].pc;
  assign if_instruction = fifo[head].instruction;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            req_addr <= pc_aligned;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            state <= IDLE;
          end else if (redirect) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (redirect) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        pc <= req_addr + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= nxt(tail);
      end
      if (pop) begin
        head <= nxt(head);
      end
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[tail] <= '{pc: req_addr, instruction: imem_rdata};
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cache model plus fetch-stream scoreboard,
// directed scenarios followed by randomized redirect/backpressure.
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'h6000_0000;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  if_fetch #(
    .RESET_PC (RPC),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_read     (imem_read),
    .imem_address  (imem_address),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instruction(if_instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb[$];
  int          checks;
  int          failures;
  int          pops;
  bit          mon_en;
  bit          busy;
  bit          dropped;
  bit          stray;
  bit          wrap_seen;
  int          lat_left;
  int          lat_cfg;
  logic [31:0] cur_addr;
  logic [31:0] next_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // One clock of cache + control stimulus with request checks.
  task automatic cycle(input bit rd,
                       input logic [31:0] tgt,
                       input bit idr);
    bit          rsp;
    bit          req;
    logic [31:0] req_a;
    @(negedge clk);
    rsp         = busy && (lat_left == 0);
    redirect    = rd;
    redirect_pc = rd ? tgt : $urandom;
    id_ready    = idr;
    imem_resp   = rsp || stray;
    imem_rdata  = rsp ? mem(cur_addr) : $urandom;
    stray       = 1'b0;
    #1;
    req   = 1'b0;
    req_a = imem_address;
    if (busy) begin
      chk("hold_read", 32'(imem_read), 32'd1);
      chk("hold_addr", imem_address, cur_addr);
    end else begin
      chk("req_en", 32'(imem_read),
          32'(!rd && (sb.size() < DEPTH)));
      if (imem_read) begin
        chk("req_addr", imem_address, next_addr);
        req = 1'b1;
        if (imem_address == 32'h0) wrap_seen = 1'b1;
      end
    end
    @(posedge clk);
    if (rd) next_addr = {tgt[31:2], 2'b00};
    if (busy) begin
      if (rsp) begin
        busy = 1'b0;
        if (!dropped && !rd) begin
          sb.push_back('{pc: cur_addr, ins: mem(cur_addr)});
          next_addr = cur_addr + 32'd4;
        end
        dropped = 1'b0;
      end else begin
        lat_left--;
        if (rd) dropped = 1'b1;
      end
    end else if (req) begin
      busy     = 1'b1;
      dropped  = 1'b0;
      cur_addr = req_a;
      lat_left = (lat_cfg == 0) ? $urandom_range(2, 0)
                                : lat_cfg - 1;
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      chk("if_valid", 32'(if_valid), 32'(sb.size() != 0));
      if (if_valid && sb.size() != 0) begin
        chk("if_pc", if_pc, sb[0].pc);
        chk("if_ins", if_instruction, sb[0].ins);
      end
      if (redirect) begin
        sb.delete();
      end else if (id_ready && sb.size() != 0) begin
        void'(sb.pop_front());
        pops++;
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("rst_read", 32'(imem_read), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    busy      = 1'b0;
    dropped   = 1'b0;
    next_addr = RPC;
    sb.delete();
    imem_resp = 1'b0;
    redirect  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    stray  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] tgt;
    checks      = 0;
    failures    = 0;
    pops        = 0;
    mon_en      = 1'b0;
    busy        = 1'b0;
    dropped     = 1'b0;
    stray       = 1'b0;
    wrap_seen   = 1'b0;
    lat_left    = 0;
    lat_cfg     = 1;
    cur_addr    = '0;
    next_addr   = RPC;
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    imem_resp   = 1'b0;
    imem_rdata  = '0;

    @(posedge clk);
    #1;
    chk("reset_read", 32'(imem_read), 32'd0);
    chk("reset_valid", 32'(if_valid), 32'd0);
    chk("reset_addr", imem_address, RPC);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Streaming with a 1-cycle cache.
    repeat (14) cycle(1'b0, 32'h0, 1'b1);
    chk("stream_pops", 32'(pops >= 5), 32'd1);

    // Backpressure fills the buffer, then drains.
    repeat (12) cycle(1'b0, 32'h0, 1'b0);
    chk("buffered", 32'(sb.size()), DEPTH);
    chk("no_busy_full", 32'(busy), 32'd0);
    repeat (10) cycle(1'b0, 32'h0, 1'b1);

    // Redirect mid-WAIT with a 3-cycle cache.
    lat_cfg = 3;
    n = 0;
    while (!(busy && lat_left == 2) && n < 20) begin
      cycle(1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("wait_req3", 32'(n < 20), 32'd1);
    cycle(1'b1, 32'h6000_0101, 1'b1);
    chk("drop_next", next_addr, 32'h6000_0100);
    repeat (12) cycle(1'b0, 32'h0, 1'b1);

    // Redirect colliding with a response and a pending pop.
    lat_cfg = 2;
    n = 0;
    while (!(busy && lat_left == 0 && sb.size() == 1) && n < 40) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("wait_collide", 32'(n < 40), 32'd1);
    cycle(1'b1, 32'h6000_0400, 1'b1);
    chk("collide_flush", 32'(sb.size()), 32'd0);
    repeat (8) cycle(1'b0, 32'h0, 1'b1);

    // Reset in the middle of an outstanding request.
    lat_cfg = 3;
    n = 0;
    while (!busy && n < 20) begin
      cycle(1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("wait_req_rst", 32'(n < 20), 32'd1);
    cycle(1'b0, 32'h0, 1'b1);
    pulse_reset();
    lat_cfg = 1;
    repeat (8) cycle(1'b0, 32'h0, 1'b1);

    // Randomized redirects, latency and backpressure.
    lat_cfg = 0;
    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom_range(3, 0) == 0)
          ? 32'hFFFF_FFF0 + $urandom_range(15, 0)
          : RPC + $urandom_range(255, 0);
      cycle($urandom_range(19, 0) == 0, tgt,
            $urandom_range(9, 0) < 7);
    end

    // Address wrap past the top of memory.
    lat_cfg   = 1;
    wrap_seen = 1'b0;
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (12) cycle(1'b0, 32'h0, 1'b1);
    chk("wrap", 32'(wrap_seen), 32'd1);
    chk("total_pops", 32'(pops >= 40), 32'd1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
